md_unit: RTL and testbench

- Multiply/divide unit for the EX stage of the 5-stage MIPS pipeline; sits beside the ALU.
- Executes mult, multu, div and divu with a fixed multi-cycle latency, and writes the results into the architectural HI/LO registers.
- Handles mthi/mtlo as immediate writes.
- Exposes HI/LO continuously for mfhi/mflo.
- Drives busy so hazard control can stall later md instructions.

---
 rtl/md_unit_pkg.sv | 34 +++
 rtl/md_unit_if.sv | 20 ++
 rtl/md_unit_calc.sv | 57 +++++
 rtl/md_unit.sv | 108 ++++++++++
 tb/tb_md_unit.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the mdop encodings, the default latencies and the result payload,
// so the decoder, the hazard unit and md_unit all use a single definition.
package md_unit_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  // Latency counter width; holds latencies of up to 256 cycles.
  localparam int unsigned CNT_W           = 8;

  typedef enum logic [3:0] {
    MD_NONE  = 4'b0000,
    MD_MULT  = 4'b0001,
    MD_MULTU = 4'b0010,
    MD_DIV   = 4'b0011,
    MD_DIVU  = 4'b0100,
    MD_MTHI  = 4'b0101,
    MD_MTLO  = 4'b0110
  } mdop_e;

  // 64-bit result plus divide-by-zero flag
  typedef struct packed {
    logic              div0;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } mdRes_t;

  // True for operations that occupy the unit for several cycles
  function automatic logic isLongOp(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Request/result bundle between the EX stage and md_unit.
//   start : one-cycle request, mdop/inA/inB valid
//   mdop  : operation code (md_unit_pkg::mdop_e encodings)
//   inA   : rs operand, inB : rt operand
//   busy  : a mult/div is in flight
//   HI/LO : committed architectural HI/LO registers
interface md_unit_if;
  import md_unit_pkg::*;

  logic              start;
  logic [3:0]        mdop;
  logic [DATA_W-1:0] inA;
  logic [DATA_W-1:0] inB;
  logic              busy;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;

  modport master (output start, mdop, inA, inB, input busy, HI, LO);
  modport slave  (input start, mdop, inA, inB, output busy, HI, LO);
endinterface

// File: rtl/md_unit_calc.sv
// Combinational 64-bit result generator for mult/multu/div/divu.
//   mdop    : operation code
//   inA/inB : rs / rt operands
//   res     : {div0, hi, lo}; div0 set for a div/divu with a zero divisor
module md_unit_calc
  import md_unit_pkg::*;
(
  input  logic [3:0]        mdop,
  input  logic [DATA_W-1:0] inA,
  input  logic [DATA_W-1:0] inB,
  output mdRes_t            res
);

  logic              isSigned;
  logic              isDiv;
  logic              negA;
  logic              negB;
  logic [63:0]       extA;
  logic [63:0]       extB;
  logic [63:0]       prod;
  logic [DATA_W-1:0] magA;
  logic [DATA_W-1:0] magB;
  logic [DATA_W-1:0] divisor;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;

  always_comb begin
    isSigned = (mdop == MD_MULT) || (mdop == MD_DIV);
    isDiv    = (mdop == MD_DIV) || (mdop == MD_DIVU);
    negA     = isSigned & inA[31];
    negB     = isSigned & inB[31];

    // Low 64 bits of the extended product are correct for both signednesses
    extA = {{32{negA}}, inA};
    extB = {{32{negB}}, inB};
    prod = extA * extB;

    // Divide on magnitudes: avoids the signed overflow of 0x80000000 / -1
    // and gives truncation toward zero with remainder signed like the dividend.
    magA    = negA ? -inA : inA;
    magB    = negB ? -inB : inB;
    divisor = (magB == '0) ? 32'd1 : magB;
    quo     = magA / divisor;
    rem     = magA % divisor;

    res      = '0;
    res.div0 = isDiv && (inB == '0);
    if (isDiv) begin
      res.lo = (negA ^ negB) ? -quo : quo;
      res.hi = negA ? -rem : rem;
    end else begin
      res.hi = prod[63:32];
      res.lo = prod[31:0];
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit beside the EX-stage ALU.
// Runs mult/multu/div/divu with fixed latency and commits to HI/LO;
// mthi/mtlo write immediately. Requests while busy are dropped.
//   clk, reset : clock, asynchronous active-high reset
//   md         : request/result bundle (slave side)
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  md
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e            state;
  state_e            stateNext;
  logic [CNT_W-1:0]  counter;
  logic [CNT_W-1:0]  counterNext;
  mdRes_t            pend;
  mdRes_t            pendNext;
  mdRes_t            calcRes;
  logic [DATA_W-1:0] hiReg;
  logic [DATA_W-1:0] hiNext;
  logic [DATA_W-1:0] loReg;
  logic [DATA_W-1:0] loNext;

  md_unit_calc uCalc (
    .mdop (md.mdop),
    .inA  (md.inA),
    .inB  (md.inB),
    .res  (calcRes)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      pend    <= '0;
      hiReg   <= '0;
      loReg   <= '0;
    end else begin
      state   <= stateNext;
      counter <= counterNext;
      pend    <= pendNext;
      hiReg   <= hiNext;
      loReg   <= loNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (md.start && isLongOp(md.mdop)) stateNext = BUSY;
      BUSY:    if (counter == '0) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Counter, pending result and HI/LO updates
  always_comb begin
    counterNext = counter;
    pendNext    = pend;
    hiNext      = hiReg;
    loNext      = loReg;
    case (state)
      IDLE: begin
        if (md.start) begin
          case (md.mdop)
            MD_MULT, MD_MULTU: begin
              pendNext    = calcRes;
              counterNext = CNT_W'(MULT_CYCLES - 1);
            end
            MD_DIV, MD_DIVU: begin
              pendNext    = calcRes;
              counterNext = CNT_W'(DIV_CYCLES - 1);
            end
            MD_MTHI: hiNext = md.inA;
            MD_MTLO: loNext = md.inA;
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (counter == '0) begin
          // Divide by zero leaves HI/LO untouched
          if (!pend.div0) begin
            hiNext = pend.hi;
            loNext = pend.lo;
          end
        end else begin
          counterNext = counter - 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign md.busy = (state == BUSY);
  assign md.HI   = hiReg;
  assign md.LO   = loReg;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: table of mult/div vectors plus hand-written
// sequences for mthi/mtlo, divide by zero, requests while busy and reset.
module tb_md_unit;
  import md_unit_pkg::*;

  logic clk;
  logic reset;
  int   nVec;
  int   nErr;
  logic [31:0] mHi;
  logic [31:0] mLo;

  md_unit_if mdIf ();

  md_unit dut (
    .clk   (clk),
    .reset (reset),
    .md    (mdIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request, optionally inject a second request while busy.
  // Returns busy cycle count and HI/LO seen in the first busy cycle.
  task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] injOp, input int injAt,
                       output int cycles, output logic [31:0] hiDuring,
                       output logic [31:0] loDuring);
    @(negedge clk);
    mdIf.start = 1'b1;
    mdIf.mdop  = op;
    mdIf.inA   = a;
    mdIf.inB   = b;
    @(negedge clk);
    mdIf.start = 1'b0;
    cycles   = 0;
    hiDuring = mdIf.HI;
    loDuring = mdIf.LO;
    for (int i = 0; i < 64; i++) begin
      if (!mdIf.busy) break;
      cycles++;
      if (cycles == injAt) begin
        mdIf.start = 1'b1;
        mdIf.mdop  = injOp;
        mdIf.inA   = 32'hDEADBEEF;
        mdIf.inB   = 32'd3;
      end else begin
        mdIf.start = 1'b0;
      end
      @(negedge clk);
    end
    mdIf.start = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [31:0] hd;
    logic [31:0] ld;

    nVec = 0;
    nErr = 0;
    vecs[0] = '{MD_MULT,  32'hFFFFFFFD, 32'd5,        5,  32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{MD_DIVU,  32'd7,        32'd2,        10, 32'h00000001, 32'h00000003};
    vecs[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    vecs[5] = '{MD_MULT,  32'd7,        32'hFFFFFFFE, 5,  32'hFFFFFFFF, 32'hFFFFFFF2};
    vecs[6] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[7] = '{MD_MULTU, 32'h00010000, 32'h00010000, 5,  32'h00000001, 32'h00000000};

    reset      = 1'b1;
    mdIf.start = 1'b0;
    mdIf.mdop  = MD_NONE;
    mdIf.inA   = '0;
    mdIf.inB   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("reset_busy", 32'(mdIf.busy), 32'd0);
    check("reset_hi", mdIf.HI, 32'h0);
    check("reset_lo", mdIf.LO, 32'h0);
    mHi = 32'h0;
    mLo = 32'h0;

    // MTHI then MTLO: one-edge effect, never busy
    mdIf.start = 1'b1;
    mdIf.mdop  = MD_MTHI;
    mdIf.inA   = 32'h12345678;
    @(posedge clk);
    #1;
    check("mthi_hi", mdIf.HI, 32'h12345678);
    check("mthi_lo", mdIf.LO, 32'h0);
    check("mthi_busy", 32'(mdIf.busy), 32'd0);
    mdIf.mdop = MD_MTLO;
    mdIf.inA  = 32'h9ABCDEF0;
    @(posedge clk);
    #1;
    mdIf.start = 1'b0;
    check("mtlo_lo", mdIf.LO, 32'h9ABCDEF0);
    check("mtlo_hi", mdIf.HI, 32'h12345678);
    check("mtlo_busy", 32'(mdIf.busy), 32'd0);
    mHi = 32'h12345678;
    mLo = 32'h9ABCDEF0;

    // DIVU by zero with a MULT issued while busy: full latency, HI/LO kept
    runOp(MD_DIVU, 32'd100, 32'd0, MD_MULT, 3, cyc, hd, ld);
    check("div0_cycles", 32'(cyc), 32'd10);
    check("div0_hi", mdIf.HI, mHi);
    check("div0_lo", mdIf.LO, mLo);
    @(negedge clk);
    check("div0_no_queued_mult", 32'(mdIf.busy), 32'd0);
    check("div0_hi_after", mdIf.HI, mHi);

    // Table of mult/div vectors
    for (int i = 0; i < 8; i++) begin
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, MD_NONE, 0, cyc, hd, ld);
      check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].cyc));
      check($sformatf("v%0d_hi_during", i), hd, mHi);
      check($sformatf("v%0d_lo_during", i), ld, mLo);
      check($sformatf("v%0d_hi", i), mdIf.HI, vecs[i].hi);
      check($sformatf("v%0d_lo", i), mdIf.LO, vecs[i].lo);
      mHi = vecs[i].hi;
      mLo = vecs[i].lo;
    end

    // MTHI while a MULT is in flight is dropped; (-1)*(-1) = 1
    runOp(MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, MD_MTHI, 2, cyc, hd, ld);
    check("mthi_busy_cycles", 32'(cyc), 32'd5);
    check("mthi_busy_hi", mdIf.HI, 32'h0);
    check("mthi_busy_lo", mdIf.LO, 32'h1);
    mHi = 32'h0;
    mLo = 32'h1;

    // NONE and an undefined code do nothing
    @(negedge clk);
    mdIf.start = 1'b1;
    mdIf.mdop  = MD_NONE;
    mdIf.inA   = 32'hCAFEF00D;
    @(negedge clk);
    mdIf.mdop  = 4'hF;
    @(negedge clk);
    mdIf.start = 1'b0;
    check("undef_busy", 32'(mdIf.busy), 32'd0);
    check("undef_hi", mdIf.HI, mHi);
    check("undef_lo", mdIf.LO, mLo);

    // Reset three cycles into a DIV: clears immediately, no commit
    runOp(MD_MULTU, 32'h00000003, 32'h00000005, MD_NONE, 0, cyc, hd, ld);
    check("pre_reset_lo", mdIf.LO, 32'd15);
    mdIf.start = 1'b1;
    mdIf.mdop  = MD_DIV;
    mdIf.inA   = 32'd50;
    mdIf.inB   = 32'd7;
    @(negedge clk);
    mdIf.start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_busy", 32'(mdIf.busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_busy", 32'(mdIf.busy), 32'd0);
    check("async_reset_hi", mdIf.HI, 32'h0);
    check("async_reset_lo", mdIf.LO, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    runOp(MD_MULT, 32'd2, 32'd3, MD_NONE, 0, cyc, hd, ld);
    check("post_reset_cycles", 32'(cyc), 32'd5);
    check("post_reset_hi", mdIf.HI, 32'h0);
    check("post_reset_lo", mdIf.LO, 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
